seg7_monitor: RTL and testbench

Loopback checker for the 7-segment display path. It samples a 7-bit segment bus, waits for each pattern to hold steady, and decodes it back into a hex digit. It then checks that successive digits follow the counting display's +1 mod 16 sequence. It sits on the input side of a test build, wired to the segment lines the display driver emits, and reports digits and errors.

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/seg7_stable_filter.sv | 52 +++++
 rtl/seg7_monitor.sv | 73 +++++++
 tb/tb_seg7_monitor.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, glyph table and decode helper for the 7-segment loopback monitor.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Entry i is the glyph for hex digit i (bit0 = segment a ... bit6 = segment g).
    localparam logic [15:0][6:0] SEG_GLYPHS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic {
        ST_ACQUIRE = 1'b0,
        ST_TRACK   = 1'b1
    } mon_state_t;

    // Returns {valid, digit}; valid is 0 for anything outside the glyph table.
    function automatic logic [4:0] seg7_to_digit(input logic [6:0] pat);
        logic [4:0] res;
        res = 5'b0;
        for (int i = 0; i < 16; i++) begin
            if (pat == SEG_GLYPHS[i]) begin
                res = {1'b1, 4'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Synchronises the segment bus, waits for STABLE_CYCLES identical samples and
// strobes accept once per new stable pattern.
module seg7_stable_filter
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    output logic       accept,
    output logic [6:0] pattern
);

    localparam logic [15:0] CNT_MAX = 16'(STABLE_CYCLES - 1);

    logic [6:0]  meta_q;
    logic [6:0]  sync_q;
    logic [6:0]  prev_q;
    logic [6:0]  last_pat;
    logic [15:0] stab_cnt;

    // NOTE: every flop here uses <= so all stages sample the pre-edge values;
    // blocking assignments would collapse the synchroniser into one stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q   <= '0;
            sync_q   <= '0;
            prev_q   <= '0;
            last_pat <= SEG_BLANK;
            stab_cnt <= '0;
        end else begin
            meta_q <= seg_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
            if (sync_q != prev_q) begin
                stab_cnt <= '0;
            end else if (stab_cnt != CNT_MAX) begin
                stab_cnt <= stab_cnt + 16'd1;
            end
            if (accept) begin
                last_pat <= sync_q;
            end
        end
    end

    // The equality term keeps a saturated count from a previous pattern
    // from accepting a fresh sample on its first cycle.
    assign accept  = (stab_cnt == CNT_MAX) && (sync_q == prev_q) && (sync_q != last_pat);
    assign pattern = sync_q;

endmodule

// File: rtl/seg7_monitor.sv
// Top level: decodes accepted segment patterns, tracks the +1 mod 16 sequence
// and counts errors. Define SEG7_MON_SEQ_CHECK_EN to build the sequence check.
module seg7_monitor
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 1000,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       seg_in,
    output logic [3:0]       digit_out,
    output logic             digit_valid,
    output logic             pattern_err,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    logic       accept;
    logic [6:0] acc_pat;
    logic [4:0] dec;
    logic       is_glyph;
    logic       is_bad;
    logic       seq_bad;
    mon_state_t state;

    seg7_stable_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk    (clk),
        .rst    (rst),
        .seg_in (seg_in),
        .accept (accept),
        .pattern(acc_pat)
    );

    assign dec      = seg7_to_digit(acc_pat);
    assign is_glyph = accept && dec[4];
    assign is_bad   = accept && !dec[4] && (acc_pat != SEG_BLANK);

`ifdef SEG7_MON_SEQ_CHECK_EN
    assign seq_bad = is_glyph && (state == ST_TRACK) && (dec[3:0] != digit_out + 4'd1);
`else
    assign seq_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_ACQUIRE;
            digit_out   <= '0;
            digit_valid <= 1'b0;
            pattern_err <= 1'b0;
            seq_err     <= 1'b0;
            err_count   <= '0;
        end else begin
            digit_valid <= is_glyph;
            pattern_err <= is_bad;
            seq_err     <= seq_bad;
            if (is_glyph) begin
                digit_out <= dec[3:0];
                state     <= ST_TRACK;
            end
            // The two error sources are mutually exclusive, so +1 covers both.
            if ((is_bad || seq_bad) && (err_count != '1)) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

    assign locked = (state == ST_TRACK);

endmodule

// File: tb/tb_seg7_monitor.sv
// Directed bench for seg7_monitor with STABLE_CYCLES=8, ERR_W=8.
module tb_seg7_monitor;

    localparam int SC = 8;
`ifdef SEG7_MON_SEQ_CHECK_EN
    localparam int SEQ_EN = 1;
`else
    localparam int SEQ_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg_in = 7'h00;
    logic [3:0] digit_out;
    logic       digit_valid;
    logic       pattern_err;
    logic       seq_err;
    logic       locked;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;
    int dv_cnt   = 0;
    int pe_cnt   = 0;
    int se_cnt   = 0;
    int lat;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg7_monitor #(.STABLE_CYCLES(SC), .ERR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .digit_out  (digit_out),
        .digit_valid(digit_valid),
        .pattern_err(pattern_err),
        .seq_err    (seq_err),
        .locked     (locked),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            dv_cnt += int'(digit_valid);
            pe_cnt += int'(pattern_err);
            se_cnt += int'(seq_err);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        seg_in = p;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        check("rst_digit", 32'(digit_out), 0);
        check("rst_valid", 32'(digit_valid), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_err", 32'(err_count), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // First digit with latency measurement: 2 + SC + 1 edges.
        seg_in = 7'h3F;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (digit_valid) begin
                lat = n;
                break;
            end
        end
        check("latency", 32'(lat), 32'(2 + SC + 1));
        hold(7'h3F, 9);
        hold(7'h06, 20);
        hold(7'h5B, 20);
        check("seq012_digit", 32'(digit_out), 2);
        check("seq012_dv", 32'(dv_cnt), 3);
        check("seq012_locked", 32'(locked), 1);
        check("seq012_err", 32'(err_count), 0);

        // Short glitch inside a held pattern.
        hold(7'h4F, 20);
        hold(7'h7F, 5);
        hold(7'h4F, 20);
        check("glitch_dv", 32'(dv_cnt), 4);
        check("glitch_digit", 32'(digit_out), 3);

        // Walk 4..F, then wrap to 0, then jump to 3.
        for (int i = 4; i < 16; i++) hold(glyph[i], 20);
        check("walk_digit", 32'(digit_out), 15);
        hold(7'h3F, 20);
        check("wrap_digit", 32'(digit_out), 0);
        check("wrap_seq", 32'(se_cnt), 0);
        hold(7'h4F, 20);
        check("jump_digit", 32'(digit_out), 3);
        check("jump_seq", 32'(se_cnt), 32'(SEQ_EN));
        check("jump_err", 32'(err_count), 32'(SEQ_EN));
        check("jump_dv", 32'(dv_cnt), 18);

        // Non-glyph held long: one pattern_err only.
        hold(7'h55, 40);
        check("bad_pe", 32'(pe_cnt), 1);
        check("bad_digit", 32'(digit_out), 3);
        check("bad_dv", 32'(dv_cnt), 18);
        check("bad_err", 32'(err_count), 32'(SEQ_EN + 1));

        // Blank between 0 and 1 is transparent.
        hold(7'h3F, 20);
        check("pre_blank_seq", 32'(se_cnt), 32'(2 * SEQ_EN));
        hold(7'h00, 20);
        check("blank_dv", 32'(dv_cnt), 19);
        check("blank_pe", 32'(pe_cnt), 1);
        check("blank_digit", 32'(digit_out), 0);
        hold(7'h06, 20);
        check("post_blank_digit", 32'(digit_out), 1);
        check("post_blank_dv", 32'(dv_cnt), 20);
        check("post_blank_seq", 32'(se_cnt), 32'(2 * SEQ_EN));
        check("post_blank_err", 32'(err_count), 32'(2 * SEQ_EN + 1));
        check("post_blank_locked", 32'(locked), 1);

        // Reset in the middle of a stability count.
        hold(7'h5B, 6);
        rst = 1'b1;
        #1;
        check("mid_rst_digit", 32'(digit_out), 0);
        check("mid_rst_locked", 32'(locked), 0);
        check("mid_rst_err", 32'(err_count), 0);
        check("mid_rst_pulses", 32'({digit_valid, pattern_err, seq_err}), 0);
        seg_in = 7'h06;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        hold(7'h06, 20);
        check("post_rst_digit", 32'(digit_out), 1);
        check("post_rst_dv", 32'(dv_cnt), 21);
        check("post_rst_locked", 32'(locked), 1);
        check("post_rst_seq", 32'(se_cnt), 32'(2 * SEQ_EN));

        // Error counter saturation with 300 pattern errors.
        rst = 1'b1;
        seg_in = 7'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 300; i++) hold((i % 2 == 0) ? 7'h55 : 7'h2A, 12);
        hold(7'h2A, 10);
        check("sat_pe", 32'(pe_cnt), 301);
        check("sat_err", 32'(err_count), 255);
        check("sat_locked", 32'(locked), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
